gomoku_ctrl: RTL and testbench

- Game-logic stage directly upstream of the VGA renderer.
- Turns five key inputs into cursor movement and stone placement on the 16x16 five-in-a-row board.
- Drives the renderer's board, pointer_loc_x, pointer_loc_y and gaming_status inputs.
- After each placement, a sequential scanner checks the four line directions around the new stone for a five-in-a-row, then updates the result and the turn.

---
 rtl/gomoku_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_gomoku_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gomoku_ctrl.sv
// Game-logic controller for a 16x16 five-in-a-row board: key edge detection, cursor,
// stone placement and a sequential four-direction win scanner feeding the VGA renderer.
module gomoku_ctrl #(
   parameter int BOARD_DIM = 16,
   parameter int WIN_LEN   = 5,
   parameter int START_X   = 7,
   parameter int START_Y   = 7
) (
   input  logic                               Clck,
   input  logic                               Reset,
   input  logic                               key_left,
   input  logic                               key_right,
   input  logic                               key_up,
   input  logic                               key_down,
   input  logic                               key_place,
   output logic [2*BOARD_DIM*BOARD_DIM-1:0]   board,
   output logic [3:0]                         pointer_loc_x,
   output logic [3:0]                         pointer_loc_y,
   output logic [1:0]                         gaming_status,
   output logic                               turn,
   output logic                               busy
);

   localparam int          BOARD_BITS = 2 * BOARD_DIM * BOARD_DIM;
   localparam logic [3:0]  MAX_COORD  = 4'(BOARD_DIM - 1);
   localparam logic [2:0]  MAX_STEP   = 3'(WIN_LEN - 1);
   localparam logic [3:0]  WIN_RUN    = 4'(WIN_LEN);

   typedef enum logic [2:0] {IDLE, WRITE, SCAN, NEXT_DIR, RESOLVE} state_t;

   state_t                  state_q, state_d;
   logic [BOARD_BITS-1:0]   board_q, board_d;
   logic [3:0]              px_q, px_d, py_q, py_d;
   logic [3:0]              ox_q, ox_d, oy_q, oy_d;
   logic [1:0]              status_q, status_d;
   logic [1:0]              p_q, p_d;
   logic                    turn_q, turn_d;
   logic                    busy_q, busy_d;
   logic                    win_q, win_d;
   logic [8:0]              count_q, count_d;
   logic [4:0]              hist_q, hist_d;
   logic [1:0]              dir_q, dir_d;
   logic                    side_q, side_d;
   logic [2:0]              step_q, step_d;
   logic [3:0]              run_q, run_d;

   logic [4:0]              keys, ev;
   logic [4:0]              vec_x, vec_y, step_ext, probe_x, probe_y;
   logic [8:0]              probe_idx, cursor_idx, origin_idx;
   logic                    probe_hit;

   assign keys       = {key_place, key_down, key_up, key_right, key_left};
   assign ev         = keys & ~hist_q;
   assign cursor_idx = {py_q, px_q, 1'b0};
   assign origin_idx = {oy_q, ox_q, 1'b0};

   // Probe in 5-bit two's complement: any coordinate outside 0..15 has bit 4 set.
   always_comb begin
      vec_x = 5'd1;
      vec_y = 5'd0;
      case (dir_q)
         2'd0: begin vec_x = 5'd1; vec_y = 5'd0;    end
         2'd1: begin vec_x = 5'd0; vec_y = 5'd1;    end
         2'd2: begin vec_x = 5'd1; vec_y = 5'd1;    end
         default: begin vec_x = 5'd1; vec_y = 5'h1F; end
      endcase
      if (side_q) begin
         vec_x = 5'd0 - vec_x;
         vec_y = 5'd0 - vec_y;
      end
      step_ext  = {2'b00, step_q};
      probe_x   = {1'b0, ox_q} + vec_x * step_ext;
      probe_y   = {1'b0, oy_q} + vec_y * step_ext;
      probe_idx = {probe_y[3:0], probe_x[3:0], 1'b0};
      probe_hit = !probe_x[4] && !probe_y[4] && (board_q[probe_idx +: 2] == p_q);
   end

   always_comb begin
      state_d  = state_q;
      board_d  = board_q;
      px_d     = px_q;
      py_d     = py_q;
      ox_d     = ox_q;
      oy_d     = oy_q;
      status_d = status_q;
      p_d      = p_q;
      turn_d   = turn_q;
      busy_d   = busy_q;
      win_d    = win_q;
      count_d  = count_q;
      hist_d   = keys;
      dir_d    = dir_q;
      side_d   = side_q;
      step_d   = step_q;
      run_d    = run_q;
      case (state_q)
         IDLE: begin
            if (ev[4]) begin
               if (status_q == 2'b00 && board_q[cursor_idx +: 2] == 2'b00) begin
                  ox_d    = px_q;
                  oy_d    = py_q;
                  p_d     = turn_q ? 2'b10 : 2'b01;
                  busy_d  = 1'b1;
                  state_d = WRITE;
               end
            end else if (ev[0]) begin
               if (px_q != 4'd0) px_d = px_q - 4'd1;
            end else if (ev[1]) begin
               if (px_q != MAX_COORD) px_d = px_q + 4'd1;
            end else if (ev[2]) begin
               if (py_q != 4'd0) py_d = py_q - 4'd1;
            end else if (ev[3]) begin
               if (py_q != MAX_COORD) py_d = py_q + 4'd1;
            end
         end
         WRITE: begin
            board_d[origin_idx +: 2] = p_q;
            dir_d   = 2'd0;
            side_d  = 1'b0;
            step_d  = 3'd1;
            run_d   = 4'd1;
            win_d   = 1'b0;
            state_d = SCAN;
         end
         SCAN: begin
            if (probe_hit) begin
               run_d  = run_q + 4'd1;
               step_d = step_q + 3'd1;
            end
            // A side ends on a miss or after the longest useful reach.
            if (!probe_hit || step_q == MAX_STEP) begin
               if (!side_q) begin
                  side_d = 1'b1;
                  step_d = 3'd1;
               end else begin
                  state_d = NEXT_DIR;
               end
            end
         end
         NEXT_DIR: begin
            if (run_q >= WIN_RUN) begin
               win_d   = 1'b1;
               state_d = RESOLVE;
            end else if (dir_q == 2'd3) begin
               win_d   = 1'b0;
               state_d = RESOLVE;
            end else begin
               dir_d   = dir_q + 2'd1;
               side_d  = 1'b0;
               step_d  = 3'd1;
               run_d   = 4'd1;
               state_d = SCAN;
            end
         end
         RESOLVE: begin
            if (win_q) begin
               status_d = p_q;
            end else begin
               count_d = count_q + 9'd1;
               if (count_q == 9'd255) status_d = 2'b11;
               turn_d = ~turn_q;
            end
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clck) begin
      if (!Reset) begin
         state_q  <= IDLE;
         board_q  <= '0;
         px_q     <= 4'(START_X);
         py_q     <= 4'(START_Y);
         ox_q     <= 4'd0;
         oy_q     <= 4'd0;
         status_q <= 2'b00;
         p_q      <= 2'b00;
         turn_q   <= 1'b0;
         busy_q   <= 1'b0;
         win_q    <= 1'b0;
         count_q  <= 9'd0;
         hist_q   <= 5'd0;
         dir_q    <= 2'd0;
         side_q   <= 1'b0;
         step_q   <= 3'd1;
         run_q    <= 4'd1;
      end else begin
         state_q  <= state_d;
         board_q  <= board_d;
         px_q     <= px_d;
         py_q     <= py_d;
         ox_q     <= ox_d;
         oy_q     <= oy_d;
         status_q <= status_d;
         p_q      <= p_d;
         turn_q   <= turn_d;
         busy_q   <= busy_d;
         win_q    <= win_d;
         count_q  <= count_d;
         hist_q   <= hist_d;
         dir_q    <= dir_d;
         side_q   <= side_d;
         step_q   <= step_d;
         run_q    <= run_d;
      end
   end

   assign board         = board_q;
   assign pointer_loc_x = px_q;
   assign pointer_loc_y = py_q;
   assign gaming_status = status_q;
   assign turn          = turn_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_gomoku_ctrl.sv
// Directed bench for gomoku_ctrl: cursor saturation, placement, rejection, wins,
// and reset during a scan, with expectations queued ahead of each DUT response.
module tb_gomoku_ctrl;

   logic         Clck = 1'b0;
   logic         Reset = 1'b0;
   logic [4:0]   keys = 5'd0;
   logic [511:0] board;
   logic [3:0]   pointer_loc_x, pointer_loc_y;
   logic [1:0]   gaming_status;
   logic         turn, busy;

   typedef struct {
      string        tag;
      logic [511:0] val;
   } exp_t;

   exp_t         sbq[$];
   int           checks = 0;
   int           errors = 0;
   logic [511:0] bModel;
   int           curX, curY;
   logic         tModel;
   logic [1:0]   sModel;

   gomoku_ctrl dut (
      .Clck(Clck),
      .Reset(Reset),
      .key_left(keys[0]),
      .key_right(keys[1]),
      .key_up(keys[2]),
      .key_down(keys[3]),
      .key_place(keys[4]),
      .board(board),
      .pointer_loc_x(pointer_loc_x),
      .pointer_loc_y(pointer_loc_y),
      .gaming_status(gaming_status),
      .turn(turn),
      .busy(busy)
   );

   always #5 Clck = ~Clck;

   initial begin
      #5000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick;
      @(posedge Clck);
      #1;
   endtask

   task automatic pushExpected(input string tag, input logic [511:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sbq.push_back(e);
   endtask

   task automatic checkOutput(input logic [511:0] obs);
      exp_t e;
      checks++;
      if (sbq.size() == 0) begin
         errors++;
         $error("[TB] FAIL scoreboard_empty observed=%0h expected=none", obs);
      end else begin
         e = sbq.pop_front();
         assert (obs === e.val)
         else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic applyStimulus(input int idx, input int cycles);
      keys[idx] = 1'b1;
      repeat (cycles) tick();
      keys[idx] = 1'b0;
      tick();
   endtask

   task automatic doReset;
      Reset = 1'b0;
      keys  = 5'd0;
      tick();
      tick();
      Reset  = 1'b1;
      bModel = '0;
      curX   = 7;
      curY   = 7;
      tModel = 1'b0;
      sModel = 2'b00;
   endtask

   task automatic moveTo(input int x, input int y);
      while (curX < x) begin applyStimulus(1, 1); curX++; end
      while (curX > x) begin applyStimulus(0, 1); curX--; end
      while (curY < y) begin applyStimulus(3, 1); curY++; end
      while (curY > y) begin applyStimulus(2, 1); curY--; end
      pushExpected("ptr_x", 512'(curX));
      pushExpected("ptr_y", 512'(curY));
      checkOutput(512'(pointer_loc_x));
      checkOutput(512'(pointer_loc_y));
   endtask

   task automatic placeStone(input int x, input int y, input bit expectWin);
      logic [1:0] p;
      int n;
      moveTo(x, y);
      p = tModel ? 2'b10 : 2'b01;
      bModel[x*2 + y*32 +: 2] = p;
      pushExpected("busy_rise", 512'(1));
      pushExpected("board_write", bModel);
      keys[4] = 1'b1;
      tick();
      checkOutput(512'(busy));
      keys[4] = 1'b0;
      tick();
      checkOutput(board);
      n = 1;
      while (busy === 1'b1 && n < 60) begin
         tick();
         n++;
      end
      if (expectWin) sModel = p;
      else tModel = ~tModel;
      pushExpected("latency_le_39", 512'(1));
      pushExpected("turn", 512'(tModel));
      pushExpected("status", 512'(sModel));
      checkOutput(512'(n <= 39));
      checkOutput(512'(turn));
      checkOutput(512'(gaming_status));
   endtask

   task automatic rejectedPlace(input string tag);
      pushExpected({tag, "_busy"}, 512'(0));
      pushExpected({tag, "_board"}, bModel);
      pushExpected({tag, "_turn"}, 512'(tModel));
      pushExpected({tag, "_status"}, 512'(sModel));
      keys[4] = 1'b1;
      tick();
      checkOutput(512'(busy));
      keys[4] = 1'b0;
      repeat (3) tick();
      checkOutput(board);
      checkOutput(512'(turn));
      checkOutput(512'(gaming_status));
   endtask

   initial begin
      int n;
      doReset();
      pushExpected("rst_board", '0);
      pushExpected("rst_x", 512'(7));
      pushExpected("rst_y", 512'(7));
      pushExpected("rst_status", 512'(0));
      pushExpected("rst_turn", 512'(0));
      pushExpected("rst_busy", 512'(0));
      checkOutput(board);
      checkOutput(512'(pointer_loc_x));
      checkOutput(512'(pointer_loc_y));
      checkOutput(512'(gaming_status));
      checkOutput(512'(turn));
      checkOutput(512'(busy));

      $display("[TB] held right key then saturating pulses");
      pushExpected("held_right_x", 512'(8));
      applyStimulus(1, 20);
      checkOutput(512'(pointer_loc_x));
      pushExpected("saturate_right_x", 512'(15));
      repeat (10) applyStimulus(1, 1);
      checkOutput(512'(pointer_loc_x));
      curX = 15;
      pushExpected("saturate_up_y", 512'(0));
      repeat (9) applyStimulus(2, 1);
      checkOutput(512'(pointer_loc_y));
      curY = 0;

      $display("[TB] first placement and rejections");
      placeStone(7, 7, 1'b0);
      rejectedPlace("occupied");

      moveTo(8, 7);
      bModel[8*2 + 7*32 +: 2] = 2'b10;
      pushExpected("busy_drop_board", bModel);
      pushExpected("busy_drop_x", 512'(8));
      pushExpected("busy_drop_turn", 512'(0));
      keys[4] = 1'b1;
      tick();
      keys[4] = 1'b0;
      tick();
      keys[4] = 1'b1;
      keys[1] = 1'b1;
      tick();
      keys = 5'd0;
      n = 0;
      while (busy === 1'b1 && n < 60) begin
         tick();
         n++;
      end
      tModel = 1'b0;
      checkOutput(board);
      checkOutput(512'(pointer_loc_x));
      checkOutput(512'(turn));

      $display("[TB] horizontal win for player 1");
      doReset();
      for (int i = 0; i < 4; i++) begin
         placeStone(i, 0, 1'b0);
         placeStone(i, 5, 1'b0);
      end
      placeStone(4, 0, 1'b1);
      moveTo(5, 5);
      rejectedPlace("after_win");

      $display("[TB] anti-diagonal win for player 2, last stone in the middle");
      doReset();
      placeStone(10, 10, 1'b0);
      placeStone(4, 0, 1'b0);
      placeStone(10, 11, 1'b0);
      placeStone(3, 1, 1'b0);
      placeStone(10, 12, 1'b0);
      placeStone(1, 3, 1'b0);
      placeStone(12, 14, 1'b0);
      placeStone(0, 4, 1'b0);
      placeStone(14, 14, 1'b0);
      placeStone(2, 2, 1'b1);

      $display("[TB] reset during scan");
      doReset();
      placeStone(7, 7, 1'b0);
      placeStone(0, 15, 1'b0);
      moveTo(8, 7);
      pushExpected("mid_scan_busy", 512'(1));
      keys[4] = 1'b1;
      tick();
      keys[4] = 1'b0;
      repeat (3) tick();
      checkOutput(512'(busy));
      pushExpected("abort_board", '0);
      pushExpected("abort_busy", 512'(0));
      pushExpected("abort_x", 512'(7));
      pushExpected("abort_y", 512'(7));
      pushExpected("abort_status", 512'(0));
      pushExpected("abort_turn", 512'(0));
      Reset = 1'b0;
      tick();
      checkOutput(board);
      checkOutput(512'(busy));
      checkOutput(512'(pointer_loc_x));
      checkOutput(512'(pointer_loc_y));
      checkOutput(512'(gaming_status));
      checkOutput(512'(turn));
      Reset = 1'b1;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
